// File: rtl/pet2001_pkg.sv
// Shared definitions for the PET 2001 video RAM scheduler.
package pet2001_pkg;

    localparam int CYC_PER_US_DEF     = 50;
    localparam int VID_STREAK_MAX_DEF = 2;
    localparam int VRAM_AW            = 10;

    // Who drives the single RAM port in a given system clock cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

endpackage

// File: rtl/pet2001_ce_div.sv
// CPU cycle divider: free-running slot counter in normal mode, held at zero
// in turbo, restarted on any change of the speed switch.
module pet2001_ce_div #(
    parameter int CYC_PER_US = 50
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clk_speed,
    output logic slot,
    output logic speed_chg
);

    localparam int CW = $clog2(CYC_PER_US);

    logic [CW-1:0] cnt;
    logic          speed_q;

    assign speed_chg = clk_speed ^ speed_q;
    // The CPU slot is decided one cycle early so the grant lands on the last count.
    assign slot      = !clk_speed && (cnt == CW'(CYC_PER_US - 2));

    // Counter and speed history; reset samples the switch so release is not seen as an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            speed_q <= clk_speed;
        end else begin
            speed_q <= clk_speed;
            if (speed_chg || clk_speed)
                cnt <= '0;
            else if (cnt == CW'(CYC_PER_US - 1))
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/pet2001_vram_sched.sv
// Single-port video RAM arbiter between the 6502 bus and the character fetcher.
// One owner per system clock cycle; the owner of the next cycle is registered.
module pet2001_vram_sched
    import pet2001_pkg::*;
#(
    parameter int CYC_PER_US     = CYC_PER_US_DEF,
    parameter int VID_STREAK_MAX = VID_STREAK_MAX_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clk_speed,
    input  logic               clk_stop,
    output logic               cpu_ce,
    input  logic               cpu_vsel,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic               cpu_we,
    input  logic [7:0]         cpu_wdata,
    output logic [7:0]         cpu_rdata,
    input  logic               vid_req,
    input  logic [VRAM_AW-1:0] vid_addr,
    output logic               vid_busy,
    output logic               vid_ack,
    output logic [7:0]         vid_rdata,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic               ram_we,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata
);

    localparam int SW = $clog2(VID_STREAK_MAX + 1);

    owner_t               own_q;
    logic [SW-1:0]        streak;
    logic [SW-1:0]        streak_inc;
    logic                 pending;
    logic [VRAM_AW-1:0]   pend_addr;
    logic                 slot;
    logic                 speed_chg;
    logic                 rd_vld;
    logic [7:0]           vid_rdata_q;

    pet2001_ce_div #(.CYC_PER_US(CYC_PER_US)) u_ce_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_speed (clk_speed),
        .slot      (slot),
        .speed_chg (speed_chg)
    );

    // Streak saturates; only its comparison against the limit matters.
    assign streak_inc = (streak == SW'(VID_STREAK_MAX)) ? streak : streak + SW'(1);

    // Owner arbiter: CPU slot wins in normal mode, video gets bounded priority in turbo.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            own_q  <= OWN_IDLE;
            streak <= '0;
        end else if (speed_chg) begin
            own_q  <= OWN_IDLE;
            streak <= '0;
        end else if (!clk_speed) begin
            if (slot && !clk_stop) begin
                own_q  <= OWN_CPU;
                streak <= '0;
            end else if (pending && own_q != OWN_VID) begin
                own_q  <= OWN_VID;
                streak <= streak_inc;
            end else begin
                own_q  <= OWN_IDLE;
            end
        end else begin
            if (pending && own_q != OWN_VID &&
                (streak < SW'(VID_STREAK_MAX) || clk_stop)) begin
                own_q  <= OWN_VID;
                streak <= streak_inc;
            end else if (!clk_stop) begin
                own_q  <= OWN_CPU;
                streak <= '0;
            end else begin
                own_q  <= OWN_IDLE;
            end
        end
    end

    // Fetch request latch; clears at the end of the VID slot that serves it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            pend_addr <= '0;
        end else if (own_q == OWN_VID) begin
            pending   <= 1'b0;
        end else if (vid_req && !pending) begin
            pending   <= 1'b1;
            pend_addr <= vid_addr;
        end
    end

    // Return path: RAM data arrives one cycle after the slot that addressed it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vid_ack     <= 1'b0;
            rd_vld      <= 1'b0;
            cpu_rdata   <= '0;
            vid_rdata_q <= '0;
        end else begin
            vid_ack <= (own_q == OWN_VID);
            rd_vld  <= (own_q == OWN_CPU) && cpu_vsel;
            if (rd_vld)
                cpu_rdata <= ram_rdata;
            if (vid_ack)
                vid_rdata_q <= ram_rdata;
        end
    end

    // The fetched byte is presented straight from RAM during the ack cycle, then held.
    assign vid_rdata = vid_ack ? ram_rdata : vid_rdata_q;
    assign vid_busy  = pending;
    assign cpu_ce    = (own_q == OWN_CPU);
    assign ram_addr  = cpu_ce ? cpu_addr : pend_addr;
    assign ram_we    = cpu_ce & cpu_vsel & cpu_we;
    assign ram_wdata = cpu_wdata;

endmodule
